// File: rtl/div_control_param.sv
// div_control_param
//   Control FSM for a parametrised shift-subtract (restoring) divider datapath.
//   Sequences operand load, WIDTH subtract/shift iterations, the final
//   remainder right-shift and an optional signed fix-up, with a busy/done
//   handshake and divide-by-zero detection.
//
// Ports
//   clk          clock, all state changes on posedge
//   reset        asynchronous active-high reset
//   run          start request, sampled only in IDLE
//   signed_mode  signed divide request, sampled with run
//   dd_sign      dividend MSB, sampled with run
//   dv_sign      divisor MSB, sampled with run
//   div_zero     divisor == 0 flag from datapath, sampled with run
//   msb          sign of ALU difference (remainder_hi - divisor), this cycle
//   load_ctrl    load operands into datapath registers
//   w_ctrl       write ALU result into remainder upper half
//   subu_ctrl    ALU funct code
//   sll_ctrl     shift remainder register left by one
//   q_bit        quotient bit shifted into remainder LSB
//   srl_ctrl     shift remainder upper half right by one
//   neg_q_ctrl   negate quotient
//   neg_r_ctrl   negate remainder
//   iter_cnt     remaining-iteration counter
//   busy         operation in progress
//   ready        ~busy
//   done         one-cycle completion pulse
//   dz_err       one-cycle divide-by-zero pulse, coincident with done
module div_control_param #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [5:0]  SUBU_FUNCT = 6'b100011,
  parameter logic [5:0]  NOP_FUNCT  = 6'b000000,
  parameter bit          SIGNED_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     signed_mode,
  input  logic                     dd_sign,
  input  logic                     dv_sign,
  input  logic                     div_zero,
  input  logic                     msb,
  output logic                     load_ctrl,
  output logic                     w_ctrl,
  output logic [5:0]               subu_ctrl,
  output logic                     sll_ctrl,
  output logic                     q_bit,
  output logic                     srl_ctrl,
  output logic                     neg_q_ctrl,
  output logic                     neg_r_ctrl,
  output logic [$clog2(WIDTH)-1:0] iter_cnt,
  output logic                     busy,
  output logic                     ready,
  output logic                     done,
  output logic                     dz_err
);

  localparam int unsigned        CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]    CntInit = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]    CntOne  = CntW'(1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StIter = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StSign = 3'd4;
  localparam logic [2:0] StDone = 3'd5;
  localparam logic [2:0] StDz   = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            signed_q, signed_d;
  logic            dd_sign_q, dd_sign_d;
  logic            dv_sign_q, dv_sign_d;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    dd_sign_d = dd_sign_q;
    dv_sign_d = dv_sign_q;
    case (state_q)
      StIdle: begin
        if (run) begin
          if (div_zero) begin
            state_d = StDz;
          end else begin
            state_d   = StLoad;
            signed_d  = signed_mode & SIGNED_EN;
            dd_sign_d = dd_sign;
            dv_sign_d = dv_sign;
          end
        end
      end
      StLoad: begin
        cnt_d   = CntInit;
        state_d = StIter;
      end
      StIter: begin
        // Counter holds at zero on exit so IDLE always shows 0.
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StFix:   state_d = signed_q ? StSign : StDone;
      StSign:  state_d = StDone;
      StDone:  state_d = StIdle;
      StDz:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      dd_sign_q <= 1'b0;
      dv_sign_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      dd_sign_q <= dd_sign_d;
      dv_sign_q <= dv_sign_d;
    end
  end

  // Outputs: Moore, except w_ctrl/q_bit which follow msb during ITER.
  always_comb begin
    load_ctrl  = 1'b0;
    w_ctrl     = 1'b0;
    subu_ctrl  = NOP_FUNCT;
    sll_ctrl   = 1'b0;
    q_bit      = 1'b0;
    srl_ctrl   = 1'b0;
    neg_q_ctrl = 1'b0;
    neg_r_ctrl = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    dz_err     = 1'b0;
    case (state_q)
      StLoad: begin
        load_ctrl = 1'b1;
        sll_ctrl  = 1'b1;
        busy      = 1'b1;
      end
      StIter: begin
        subu_ctrl = SUBU_FUNCT;
        sll_ctrl  = 1'b1;
        w_ctrl    = ~msb;
        q_bit     = ~msb;
        busy      = 1'b1;
      end
      StFix: begin
        srl_ctrl = 1'b1;
        busy     = 1'b1;
      end
      StSign: begin
        neg_q_ctrl = dd_sign_q ^ dv_sign_q;
        neg_r_ctrl = dd_sign_q;
        busy       = 1'b1;
      end
      StDone: done = 1'b1;
      StDz: begin
        done   = 1'b1;
        dz_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign ready    = ~busy;
  assign iter_cnt = cnt_q;

endmodule
